note_frame_rx: RTL

- Upstream stage of the tone generators: receives the PIC's SPI note frames and presents stable per-voice period words plus waveform/notes control to the square/sawtooth/triangle/sine generators and the output mixer.
- Oversamples sck/sdi in the clk domain, hunts for a sync word, then deserialises four 32-bit words.
- Publishes all fields atomically, once per complete frame, with timeout recovery from truncated frames.

---
 rtl/note_pkg.sv | 35 +++
 rtl/note_frame_rx_if.sv | 30 +++
 rtl/sck_sync_edge.sv | 33 +++
 rtl/note_frame_rx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_pkg : shared types/constants for the PIC note-frame receiver     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package note_pkg;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    SAW    = 2'd1,
    TRI    = 2'd2,
    SINE   = 2'd3
  } waveform_t;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    PRD1 = 3'd1,
    PRD2 = 3'd2,
    PRD3 = 3'd3,
    CTRL = 3'd4
  } rx_state_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'h0000FFFF;
  localparam int          PRD_W_DEFAULT     = 32;

  localparam int WF_LSB    = 0;
  localparam int NOTES_LSB = 2;
  localparam int CSUM_LSB  = 24;

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_frame_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_frame_rx_if : SPI pins from the PIC and the published fields     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface note_frame_rx_if #(
  parameter int PRD_W = note_pkg::PRD_W_DEFAULT
);
  logic             sck;
  logic             sdi;
  logic [PRD_W-1:0] prd1;
  logic [PRD_W-1:0] prd2;
  logic [PRD_W-1:0] prd3;
  logic [1:0]       waveform;
  logic [1:0]       notes;
  logic             frame_valid;
  logic             frame_err;

  // master = PIC side (drives SPI), slave = receiver (drives fields)
  modport master (
    output sck, sdi,
    input  prd1, prd2, prd3, waveform, notes, frame_valid, frame_err
  );

  modport slave (
    input  sck, sdi,
    output prd1, prd2, prd3, waveform, notes, frame_valid, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/sck_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sck_sync_edge : 2-flop sync of sck/sdi plus sck rising-edge strobe    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sck_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic sck,
  input  logic sdi,
  output logic bit_stb,
  output logic bit_val
);

  logic [2:0] r_sck;
  logic [1:0] r_sdi;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck <= '0;
      r_sdi <= '0;
    end else begin
      r_sck <= {r_sck[1:0], sck};
      r_sdi <= {r_sdi[0], sdi};
    end
  end

  // r_sck[2] is the delayed copy used only for edge detection
  assign bit_stb = r_sck[1] & ~r_sck[2];
  assign bit_val = r_sdi[1];

endmodule
`default_nettype wire

// File: rtl/note_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_frame_rx : SPI note-frame receiver, atomic field publish         |
// | Optional CTRL checksum: define NOTE_FRAME_CHECKSUM_EN.  Rev 1.0       |
// +----------------------------------------------------------------------+
module note_frame_rx
  import note_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          PRD_W          = PRD_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  note_frame_rx_if.slave  bus
);

  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic             w_bit_stb;
  logic             w_bit_val;
  logic [31:0]      w_word;
  logic [31:0]      w_window;
  logic             w_word_done;
  logic             w_csum_ok;

  rx_state_t        r_state;
  logic [30:0]      r_window;
  logic [30:0]      r_shadow;
  logic [4:0]       r_bit_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [31:0]      r_stage1;
  logic [31:0]      r_stage2;
  logic [31:0]      r_stage3;
  logic [PRD_W-1:0] r_prd1;
  logic [PRD_W-1:0] r_prd2;
  logic [PRD_W-1:0] r_prd3;
  waveform_t        r_waveform;
  logic [1:0]       r_notes;
  logic             r_frame_valid;
  logic             r_frame_err;

  sck_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .sck     (bus.sck),
    .sdi     (bus.sdi),
    .bit_stb (w_bit_stb),
    .bit_val (w_bit_val)
  );

  assign w_word      = {r_shadow, w_bit_val};
  assign w_window    = {r_window, w_bit_val};
  assign w_word_done = w_bit_stb && (r_bit_cnt == 5'd31);

`ifdef NOTE_FRAME_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_csum <= '0;
    end else if (r_state == HUNT) begin
      r_csum <= '0;
    end else if (w_word_done && (r_state != CTRL)) begin
      r_csum <= r_csum ^ xor_bytes(w_word);
    end
  end

  assign w_csum_ok = (w_word[CSUM_LSB +: 8] == r_csum);
`else
  assign w_csum_ok = 1'b1;
`endif

  // Shadow/window keep only 31 bits: the 32nd is always the live sdi sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= HUNT;
      r_window      <= '0;
      r_shadow      <= '0;
      r_bit_cnt     <= '0;
      r_to_cnt      <= '0;
      r_stage1      <= '0;
      r_stage2      <= '0;
      r_stage3      <= '0;
      r_prd1        <= '0;
      r_prd2        <= '0;
      r_prd3        <= '0;
      r_waveform    <= SQUARE;
      r_notes       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        HUNT: begin
          r_to_cnt <= '0;
          if (w_bit_stb) begin
            if (w_window == SYNC_WORD) begin
              r_state   <= PRD1;
              r_bit_cnt <= '0;
              r_window  <= '0;
              r_shadow  <= '0;
            end else begin
              r_window <= w_window[30:0];
            end
          end
        end
        default: begin
          if (w_bit_stb) begin
            r_to_cnt  <= '0;
            r_shadow  <= w_word[30:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (w_word_done) begin
              case (r_state)
                PRD1: begin
                  r_stage1 <= w_word;
                  r_state  <= PRD2;
                end
                PRD2: begin
                  r_stage2 <= w_word;
                  r_state  <= PRD3;
                end
                PRD3: begin
                  r_stage3 <= w_word;
                  r_state  <= CTRL;
                end
                default: begin
                  if (w_csum_ok) begin
                    r_prd1        <= PRD_W'(r_stage1);
                    r_prd2        <= PRD_W'(r_stage2);
                    r_prd3        <= PRD_W'(r_stage3);
                    r_waveform    <= waveform_t'(w_word[WF_LSB +: 2]);
                    r_notes       <= w_word[NOTES_LSB +: 2];
                    r_frame_valid <= 1'b1;
                  end else begin
                    r_frame_err   <= 1'b1;
                  end
                  r_state  <= HUNT;
                  r_window <= '0;
                  r_shadow <= '0;
                  r_stage1 <= '0;
                  r_stage2 <= '0;
                  r_stage3 <= '0;
                end
              endcase
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_state     <= HUNT;
            r_window    <= '0;
            r_shadow    <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_stage1    <= '0;
            r_stage2    <= '0;
            r_stage3    <= '0;
            r_frame_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.prd1        = r_prd1;
  assign bus.prd2        = r_prd2;
  assign bus.prd3        = r_prd3;
  assign bus.waveform    = r_waveform;
  assign bus.notes       = r_notes;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire
